// File: rtl/jt49_cen_pkg.sv
// Shared constants and tap-exponent helper for the JT49 clock-enable generator.
// Used by jt49_cen_multi and the optional JT49_CEN_FRAC_EN fractional front end.
package jt49_cen_pkg;

    localparam int DIVSEL_W = 2;
    localparam int TAPEXP_W = 4;
    localparam int FRAC_W   = 16;

    // Tap exponent = packed nibble i plus prescale shift, saturated to the counter width.
    function automatic int unsigned tap_exp(
        input logic [63:0]         tapexp,
        input int                  i,
        input logic [DIVSEL_W-1:0] div_sel,
        input int                  w
    );
        logic [TAPEXP_W-1:0] raw;
        int unsigned         sum;
        raw = tapexp[i*TAPEXP_W +: TAPEXP_W];
        sum = 32'(raw) + 32'(div_sel);
        if (sum > 32'(w)) begin
            sum = 32'(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/jt49_cen_frac.sv
// Fractional-N base enable: emits num pulses per den cycles of cen.
// Only instantiated when JT49_CEN_FRAC_EN is defined; output is registered.
module jt49_cen_frac
    import jt49_cen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [FRAC_W-1:0] frac_num,
    input  logic [FRAC_W-1:0] frac_den,
    output logic              eb
);

    logic [FRAC_W-1:0] r_acc;
    logic              r_eb;
    logic              w_pass;
    logic [FRAC_W-1:0] w_acc_c;
    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W-1:0] w_diff;

    always_comb begin
        w_pass  = (frac_num >= frac_den);
        w_acc_c = (r_acc >= frac_den) ? (frac_den - FRAC_W'(1)) : r_acc;
        w_sum   = {1'b0, w_acc_c} + {1'b0, frac_num};
        // Result is below den, so the low bits hold the exact difference.
        w_diff  = w_sum[FRAC_W-1:0] - frac_den;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_eb  <= 1'b0;
        end else if (w_pass) begin
            r_acc <= '0;
            r_eb  <= cen;
        end else if (cen) begin
            if (w_sum >= {1'b0, frac_den}) begin
                r_acc <= w_diff;
                r_eb  <= 1'b1;
            end else begin
                r_acc <= w_sum[FRAC_W-1:0];
                r_eb  <= 1'b0;
            end
        end else begin
            r_acc <= w_acc_c;
            r_eb  <= 1'b0;
        end
    end

    assign eb = r_eb;

endmodule

// File: rtl/jt49_cen_multi.sv
// Multi-tap power-of-two clock-enable generator with prescale and phase restart.
// Define JT49_CEN_FRAC_EN to derive the base enable from a num/den ratio.
module jt49_cen_multi
    import jt49_cen_pkg::*;
#(
    parameter int                       W      = 10,
    parameter int                       NTAP   = 2,
    parameter logic [NTAP*TAPEXP_W-1:0] TAPEXP = {4'd7, 4'd3}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen,
    input  logic                sync,
    input  logic [DIVSEL_W-1:0] div_sel,
`ifdef JT49_CEN_FRAC_EN
    input  logic [FRAC_W-1:0]   frac_num,
    input  logic [FRAC_W-1:0]   frac_den,
`endif
    output logic                cen_base_o,
    output logic [NTAP-1:0]     cen_o,
    output logic [W-1:0]        cnt_o
);

    logic [W-1:0]    r_cnt;
    logic [NTAP-1:0] r_cen;
    logic            r_base;
    logic            w_eb;
    logic [NTAP-1:0] w_tog;

`ifdef JT49_CEN_FRAC_EN
    jt49_cen_frac u_frac (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .frac_num (frac_num),
        .frac_den (frac_den),
        .eb       (w_eb)
    );
`else
    assign w_eb = cen;
`endif

    for (genvar g = 0; g < NTAP; g++) begin : g_tap
        int unsigned  w_exp;
        logic [W-1:0] w_mask;

        always_comb begin
            w_exp  = tap_exp(64'(TAPEXP), g, div_sel, W);
            w_mask = '0;
            for (int b = 0; b < W; b++) begin
                if (32'(b) < w_exp) begin
                    w_mask[b] = 1'b1;
                end
            end
        end

        assign w_tog[g] = ~|(r_cnt & w_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_cen  <= '0;
            r_base <= 1'b0;
        end else if (sync) begin
            r_cnt  <= '0;
            r_cen  <= '0;
            r_base <= 1'b0;
        end else begin
            if (w_eb) begin
                r_cnt <= r_cnt + W'(1);
            end
            r_cen  <= w_tog & {NTAP{w_eb}};
            r_base <= w_eb;
        end
    end

    assign cen_o      = r_cen;
    assign cen_base_o = r_base;
    assign cnt_o      = r_cnt;

endmodule

// File: tb/tb_jt49_cen_multi.sv
// Directed bench for jt49_cen_multi: vector table plus multi-cycle sequences.
// Fractional checks are compiled in when JT49_CEN_FRAC_EN is defined.
module tb_jt49_cen_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        sync = 1'b0;
    logic [1:0]  div_sel = 2'd0;
    logic [15:0] frac_num = 16'd0;
    logic [15:0] frac_den = 16'd0;
    logic        cen_base_o, u2_base;
    logic [1:0]  cen_o, u2_cen;
    logic [9:0]  cnt_o, u2_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jt49_cen_multi u_dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .sync       (sync),
        .div_sel    (div_sel),
`ifdef JT49_CEN_FRAC_EN
        .frac_num   (frac_num),
        .frac_den   (frac_den),
`endif
        .cen_base_o (cen_base_o),
        .cen_o      (cen_o),
        .cnt_o      (cnt_o)
    );

    jt49_cen_multi #(.W(10), .NTAP(2), .TAPEXP({4'd7, 4'd9})) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .sync       (sync),
        .div_sel    (div_sel),
`ifdef JT49_CEN_FRAC_EN
        .frac_num   (frac_num),
        .frac_den   (frac_den),
`endif
        .cen_base_o (u2_base),
        .cen_o      (u2_cen),
        .cnt_o      (u2_cnt)
    );

    typedef struct {
        logic       rst;
        logic       cen;
        logic       sync;
        logic [1:0] ds;
        logic [1:0] ec;
        logic       eb;
        logic [9:0] ecnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] ec,
                       input logic eb, input logic [9:0] ecnt);
        total++;
        if (cen_o !== ec || cen_base_o !== eb || cnt_o !== ecnt) begin
            bad++;
            $display("FAIL %s: got cen_o=%b base=%b cnt=%0d want cen_o=%b base=%b cnt=%0d",
                     nm, cen_o, cen_base_o, cnt_o, ec, eb, ecnt);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b0;
        sync = 1'b0;
        div_sel = 2'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
`ifndef JT49_CEN_FRAC_EN
        vec_t tv[13];
        int   j;
        int   n0;
        int   n1;
        int   wrapped;
        logic [9:0] prev;
        logic e0;
        logic e1;
        tv[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b11, 1'b1, 10'd1};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 1'b1, 10'd2};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 10'd2};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 1'b1, 10'd3};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 1'b0, 10'd0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b11, 1'b1, 10'd1};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, 2'b00, 1'b1, 10'd2};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 2'b00, 1'b0, 10'd0};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 10'd0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, 2'b11, 1'b1, 10'd1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 2'b00, 1'b0, 10'd0};
        tv[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 2'b11, 1'b1, 10'd1};
        tv[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 1'b1, 10'd2};

        do_reset();
        chk("reset_state", 2'b00, 1'b0, 10'd0);

        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst;
            cen = tv[i].cen;
            sync = tv[i].sync;
            div_sel = tv[i].ds;
            tick();
            chk($sformatf("vec%0d", i), tv[i].ec, tv[i].eb, tv[i].ecnt);
        end

        // Continuous cen, div_sel=0: tap0 every 8, tap1 every 128.
        do_reset();
        cen = 1'b1;
        for (int k = 0; k < 256; k++) begin
            tick();
            chk("cont_div0", {(k % 128) == 0, (k % 8) == 0}, 1'b1,
                10'((k + 1) % 1024));
        end

        // cen 1-of-2, div_sel=1: tap0 every 32 clocks, tap1 every 512.
        do_reset();
        div_sel = 2'd1;
        j = 0;
        n0 = 0;
        n1 = 0;
        wrapped = 0;
        prev = 10'd0;
        for (int k = 0; k < 2200; k++) begin
            cen = ((k % 2) == 0);
            tick();
            if (cen) begin
                e0 = ((j % 16) == 0);
                e1 = ((j % 256) == 0);
                j++;
                chk("half_div1", {e1, e0}, 1'b1, 10'(j % 1024));
            end else begin
                chk("half_div1_idle", 2'b00, 1'b0, 10'(j % 1024));
            end
            n0 += int'(cen_o[0]);
            n1 += int'(cen_o[1]);
            if (prev == 10'd1023 && cnt_o == 10'd0) wrapped++;
            prev = cnt_o;
        end
        chk_int("half_tap0_count", n0, 69);
        chk_int("half_tap1_count", n1, 5);
        chk_int("half_wraps", wrapped, 1);

        // sync at cnt=5.
        do_reset();
        cen = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_sync", 2'b00, 1'b1, 10'd5);
        sync = 1'b1;
        tick();
        chk("sync_cycle", 2'b00, 1'b0, 10'd0);
        sync = 1'b0;
        tick();
        chk("post_sync", 2'b11, 1'b1, 10'd1);

        // Saturated exponent on second instance: tap0=9+3 -> 10.
        do_reset();
        cen = 1'b1;
        div_sel = 2'd3;
        n0 = 0;
        for (int k = 0; k < 2100; k++) begin
            tick();
            e0 = ((k % 1024) == 0);
            total++;
            if (u2_cen !== {e0, e0}) begin
                bad++;
                $display("FAIL sat_tap k=%0d: got %b want %b", k, u2_cen, {e0, e0});
            end
            n0 += int'(u2_cen[0]);
        end
        chk_int("sat_tap0_count", n0, 3);

        // Reset mid-count at cnt=100.
        do_reset();
        cen = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        chk("pre_rst", 2'b00, 1'b1, 10'd100);
        rst = 1'b1;
        tick();
        chk("mid_rst", 2'b00, 1'b0, 10'd0);
        rst = 1'b0;
        cen = 1'b0;
        tick();
        chk("rst_idle", 2'b00, 1'b0, 10'd0);
        cen = 1'b1;
        tick();
        chk("rst_first", 2'b11, 1'b1, 10'd1);
`else
        logic [7:0] pat;
        logic       eb;
        int         win;
        pat = 8'b10100100;

        frac_num = 16'd3;
        frac_den = 16'd8;
        do_reset();
        total++;
        if (cen_base_o !== 1'b0 || cnt_o !== 10'd0) begin
            bad++;
            $display("FAIL reset_state: got base=%b cnt=%0d want 0 0", cen_base_o, cnt_o);
        end
        cen = 1'b1;
        win = 0;
        for (int k = 0; k < 65; k++) begin
            tick();
            eb = (k == 0) ? 1'b0 : pat[(k - 1) % 8];
            total++;
            if (cen_base_o !== eb) begin
                bad++;
                $display("FAIL frac3_8 k=%0d: got %b want %b", k, cen_base_o, eb);
            end
            if (k >= 1) win += int'(cen_base_o);
            if (k >= 1 && (k % 8) == 0) begin
                chk_int("frac3_8_window", win, 3);
                win = 0;
            end
        end

        frac_num = 16'd8;
        frac_den = 16'd8;
        do_reset();
        cen = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            eb = (k != 0);
            total++;
            if (cen_base_o !== eb) begin
                bad++;
                $display("FAIL frac8_8 k=%0d: got %b want %b", k, cen_base_o, eb);
            end
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jt49_cen_multi.md
# jt49_cen_multi

Parametrised clock-enable generator for the JT49 PSG core and its siblings. It divides a base clock-enable into NTAP power-of-two enable taps, with a run-time prescale selector and a synchronous phase-restart input. An optional fractional-N front end derives the base enable from an arbitrary num/den ratio. It sits between the system clock domain and the tone, noise and envelope generators.

## Interface
- W, 10: phase counter width.
- NTAP, 2: number of enable taps.
- TAPEXP, {4'd7,4'd3}: packed NTAP×4-bit tap exponents; tap i uses TAPEXP[4i+3:4i].

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  base clock enable.
- sync  in  1  phase restart; clears the counter.
- div_sel  in  2  extra prescale shift, 0..3.
- frac_num  in  16  fractional numerator (JT49_CEN_FRAC_EN only).
- frac_den  in  16  fractional denominator (JT49_CEN_FRAC_EN only).
- cen_base_o  out  1  registered effective base enable.
- cen_o  out  NTAP  registered tap enables, one-cycle pulses.
- cnt_o  out  W  current phase counter.

## Operation
- Effective base enable eb:
  - equals cen without the macro;
  - equals the fractional-generator pulse with the macro.
- Phase counter cnt:
  - increments by 1 mod 2^W on every cycle with eb=1;
  - wraps from 2^W−1 to 0 with no special action.
- Tap exponent e_i = TAPEXP_i + div_sel, saturated to W.
- Tap i toggle condition: cnt[e_i−1:0]==0.
  - e_i=0 means the tap fires on every eb.
  - e_i=W means the tap fires only at cnt==0.
- Registered outputs:
  - cen_o[i] <= eb & toggle_i & ~sync
  - cen_base_o <= eb & ~sync
- sync=1:
  - cnt <= 0 regardless of eb.
  - Output pulses are suppressed that cycle.
  - The next eb fires every tap (cnt==0).
- div_sel change:
  - The counter is not reset.
  - The new exponent applies to the next eb evaluation, i.e. the same cycle's combinational toggle.
  - Glitch-free by construction because outputs are registered.
- No state machine. Sequential state is cnt, plus acc in fractional mode.

## Timing
- Reset values: cnt=0, cen_o=0, cen_base_o=0, cnt_o=0, acc=0.
- Latency: eb at cycle n produces cen_o/cen_base_o at cycle n+1.
- cnt_o reflects the registered counter, updated in the same edge as the outputs.
- Tap pulse width: exactly one clk cycle, never back-to-back unless e_i=0 and eb is continuous.
- Reset asserted mid-count: all state returns to reset values at the next edge. The first eb after release fires all taps.
- rst has priority over sync, and sync has priority over eb.

## Configuration
- JT49_CEN_FRAC_EN defined:
  - frac_num and frac_den ports exist.
  - The 16-bit accumulator acc advances only on cycles with cen=1.
  - If acc+num ≥ den: acc <= acc+num−den and eb=1. Otherwise acc <= acc+num and eb=0.
  - Arithmetic uses 17 bits.
  - num ≥ den (including den=0) gives pass-through: eb=cen, acc held at 0.
  - num=0 with den>0 means eb is never asserted.
  - A change of num or den does not clear acc. acc is clamped to den−1 if it is out of range.
  - Fractional mode adds one register stage, so eb lags cen by one cycle.
- JT49_CEN_FRAC_EN undefined:
  - Fractional ports are absent.
  - eb=cen combinationally, with no added latency.

## Structure
- Package jt49_cen_pkg holds:
  - DIVSEL_W=2 and TAPEXP_W=4;
  - function tap_exp(TAPEXP,i,div_sel,W), which performs extraction, addition and saturation;
  - localparam FRAC_W=16.
- Sub-module jt49_cen_frac holds the fractional accumulator. It is instantiated only under JT49_CEN_FRAC_EN.

## Test plan
- Default parameters, cen=1 continuous, div_sel=0: cen_o[0] pulses every 8 clocks and cen_o[1] every 128 clocks. The first pulse of both is at cycle 1 after reset release.
- cen toggling 1-of-2, div_sel=1: cen_o[0] pulses every 32 clocks and cen_o[1] every 512 clocks. cnt_o wraps 1023→0 with no extra pulse.
- sync pulsed at cnt=5 with cen=1: no output that cycle, cnt_o=0 next cycle, then all taps pulse on the following cycle.
- TAPEXP tap0=9, div_sel=3 (saturates to 10): tap0 fires only at cnt==0, once per 1024 eb.
- Under JT49_CEN_FRAC_EN, num=3, den=8, cen=1: cen_base_o shows exactly 3 pulses per 8 clocks, with pattern repeat period 8. num=8, den=8 gives a pulse every clock.
- rst asserted for 1 cycle at cnt=100: all outputs go to 0 and cnt_o goes to 0. cen_o fires on all taps at the first cen after release.
